// File: rtl/unidade_controle.sv
// Multicycle control FSM of the 8-bit processor: sequences fetch/decode/execute/memory/write-back
// and drives the datapath selects, with a req/ready memory handshake guarded by a wait timeout.
module unidade_controle #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [2:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic [1:0] alu_op,
  output logic       alu_src_imm,
  output logic       ext_signed,
  output logic       reg_write,
  output logic       wb_sel,
  output logic       halted,
  output logic       error,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_LW   = 3'b011;
  localparam logic [2:0] OP_SW   = 3'b100;
  localparam logic [2:0] OP_BEQZ = 3'b101;
  localparam logic [2:0] OP_LI   = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  // The last waiting cycle is the one whose increment would reach MEM_TIMEOUT.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_r;
  logic [7:0] wait_r;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= S_FETCH;
      wait_r  <= 8'd0;
    end else begin
      case (state_r)
        S_FETCH: begin
          if (mem_ready) begin
            state_r <= S_DECODE;
            wait_r  <= 8'd0;
          end else if (wait_r == WAIT_LAST) begin
            state_r <= S_ERROR;
            wait_r  <= 8'd0;
          end else begin
            wait_r  <= wait_r + 8'd1;
          end
        end
        S_DECODE: begin
          wait_r <= 8'd0;
          case (opcode)
            OP_LW, OP_SW: state_r <= S_MEM;
            OP_HALT:      state_r <= S_HALT;
            default:      state_r <= S_EXEC;
          endcase
        end
        S_EXEC: begin
          wait_r <= 8'd0;
          case (opcode)
            OP_ADD, OP_SUB, OP_ADDI, OP_LI: state_r <= S_WB;
            default:                        state_r <= S_FETCH;
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            state_r <= (opcode == OP_LW) ? S_WB : S_FETCH;
            wait_r  <= 8'd0;
          end else if (wait_r == WAIT_LAST) begin
            state_r <= S_ERROR;
            wait_r  <= 8'd0;
          end else begin
            wait_r  <= wait_r + 8'd1;
          end
        end
        S_WB: begin
          state_r <= S_FETCH;
          wait_r  <= 8'd0;
        end
        S_HALT:  state_r <= S_HALT;
        S_ERROR: state_r <= S_ERROR;
        default: begin
          state_r <= S_FETCH;
          wait_r  <= 8'd0;
        end
      endcase
    end
  end

  // Strobes decode from the live state and are forced low while reset_n is low, so an
  // in-flight request is withdrawn the moment reset asserts.
  always_comb begin
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 1'b0;
    alu_op      = 2'b00;
    alu_src_imm = 1'b0;
    ext_signed  = 1'b0;
    reg_write   = 1'b0;
    wb_sel      = 1'b0;
    halted      = 1'b0;
    error       = 1'b0;
    state       = 3'd0;
    if (reset_n) begin
      state = state_r;
      case (state_r)
        S_FETCH: begin
          mem_req  = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        S_EXEC: begin
          case (opcode)
            OP_ADD: alu_op = 2'b00;
            OP_SUB: alu_op = 2'b01;
            OP_ADDI: begin
              alu_src_imm = 1'b1;
              ext_signed  = 1'b1;
            end
            OP_LI: begin
              alu_op      = 2'b10;
              alu_src_imm = 1'b1;
            end
            OP_BEQZ: begin
              pc_write   = zero;
              pc_src     = 1'b1;
              ext_signed = 1'b1;
            end
            default: alu_op = 2'b00;
          endcase
        end
        S_MEM: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_we   = (opcode == OP_SW);
        end
        S_WB: begin
          reg_write = 1'b1;
          wb_sel    = (opcode == OP_LW);
        end
        S_HALT:  halted = 1'b1;
        S_ERROR: error  = 1'b1;
        default: state  = state_r;
      endcase
    end else begin
      state = 3'd0;
    end
  end

endmodule

// File: tb/tb_unidade_controle.sv
// Bench for unidade_controle: per-instruction expected cycle sequences built from the ISA
// timing rules, a fixed ADDI vector table, timeout, halt and mid-transaction reset cases.
module tb_unidade_controle;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] opcode = 3'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       ir_write, pc_write, pc_src, mem_req, mem_we, addr_sel;
  logic [1:0] alu_op;
  logic       alu_src_imm, ext_signed, reg_write, wb_sel, halted, error;
  logic [2:0] state;

  int checks = 0;
  int failures = 0;

  unidade_controle #(.MEM_TIMEOUT(15)) dut (
    .clock(clock), .reset_n(reset_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .mem_req(mem_req),
    .mem_we(mem_we), .addr_sel(addr_sel), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
    .ext_signed(ext_signed), .reg_write(reg_write), .wb_sel(wb_sel), .halted(halted),
    .error(error), .state(state)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  op;
    logic        z;
    logic        rdy;
    logic [16:0] exp;
  } vec_t;

  vec_t q[$];
  vec_t tbl[5];

  wire [16:0] got = {ir_write, pc_write, pc_src, mem_req, mem_we, addr_sel, alu_op,
                     alu_src_imm, ext_signed, reg_write, wb_sel, halted, error, state};

  function automatic logic [16:0] mk(input logic ir, input logic pw, input logic ps,
                                     input logic rq, input logic we, input logic as,
                                     input logic [1:0] aop, input logic imm, input logic ext,
                                     input logic rw, input logic wb, input logic h,
                                     input logic e, input logic [2:0] st);
    return {ir, pw, ps, rq, we, as, aop, imm, ext, rw, wb, h, e, st};
  endfunction

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s t=%0t got=%b expected=%b", name, $time, act, req);
    end
  endtask

  task automatic push(input logic [2:0] op, input logic z, input logic r, input logic [16:0] e);
    vec_t v;
    v.op = op; v.z = z; v.rdy = r; v.exp = e;
    q.push_back(v);
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push_fetch(input logic [2:0] op, input int w);
    for (int i = 0; i < w; i++)
      push(op, rnd(), 1'b0, mk(0,0,0,1,0,0,2'b00,0,0,0,0,0,0,3'd0));
    push(op, rnd(), 1'b1, mk(1,1,0,1,0,0,2'b00,0,0,0,0,0,0,3'd0));
  endtask

  task automatic push_mem(input logic [2:0] op, input int w, input bit done);
    logic we;
    we = (op == 3'b100);
    for (int i = 0; i < w; i++)
      push(op, rnd(), 1'b0, mk(0,0,0,1,we,1,2'b00,0,0,0,0,0,0,3'd3));
    if (done) push(op, rnd(), 1'b1, mk(0,0,0,1,we,1,2'b00,0,0,0,0,0,0,3'd3));
  endtask

  // Whole instruction as the cycle-by-cycle strobe pattern the ISA timing implies.
  task automatic push_instr(input logic [2:0] op, input logic z, input int wf, input int wm);
    logic [1:0] aop;
    push_fetch(op, wf);
    push(op, rnd(), rnd(), mk(0,0,0,0,0,0,2'b00,0,0,0,0,0,0,3'd1));
    case (op)
      3'd0, 3'd1, 3'd2, 3'd6: begin
        aop = (op == 3'd1) ? 2'b01 : ((op == 3'd6) ? 2'b10 : 2'b00);
        push(op, rnd(), rnd(), mk(0,0,0,0,0,0,aop,(op == 3'd2 || op == 3'd6),(op == 3'd2),0,0,0,0,3'd2));
        push(op, rnd(), rnd(), mk(0,0,0,0,0,0,2'b00,0,0,1,0,0,0,3'd4));
      end
      3'd5: push(op, z, rnd(), mk(0,z,1,0,0,0,2'b00,0,1,0,0,0,0,3'd2));
      3'd3: begin
        push_mem(op, wm, 1'b1);
        push(op, rnd(), rnd(), mk(0,0,0,0,0,0,2'b00,0,0,1,1,0,0,3'd4));
      end
      3'd4: push_mem(op, wm, 1'b1);
      default:
        for (int i = 0; i < 20; i++)
          push(op, rnd(), rnd(), mk(0,0,0,0,0,0,2'b00,0,0,0,0,1,0,3'd5));
    endcase
  endtask

  // Entered and left on a falling edge; each entry is driven, checked, then clocked.
  task automatic run_q(input string name);
    vec_t v;
    while (q.size() > 0) begin
      v = q.pop_front();
      opcode = v.op; zero = v.z; mem_ready = v.rdy;
      #1;
      check(name, got, v.exp);
      @(negedge clock);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    mem_ready = 1'b0;
    #1;
    check("reset_gate", got, 17'd0);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    tbl[0] = '{op: 3'd2, z: 1'b0, rdy: 1'b1, exp: mk(1,1,0,1,0,0,2'b00,0,0,0,0,0,0,3'd0)};
    tbl[1] = '{op: 3'd2, z: 1'b0, rdy: 1'b1, exp: mk(0,0,0,0,0,0,2'b00,0,0,0,0,0,0,3'd1)};
    tbl[2] = '{op: 3'd2, z: 1'b0, rdy: 1'b0, exp: mk(0,0,0,0,0,0,2'b00,1,1,0,0,0,0,3'd2)};
    tbl[3] = '{op: 3'd2, z: 1'b1, rdy: 1'b1, exp: mk(0,0,0,0,0,0,2'b00,0,0,1,0,0,0,3'd4)};
    tbl[4] = '{op: 3'd2, z: 1'b0, rdy: 1'b0, exp: mk(0,0,0,1,0,0,2'b00,0,0,0,0,0,0,3'd0)};

    @(negedge clock);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      opcode = tbl[i].op; zero = tbl[i].z; mem_ready = tbl[i].rdy;
      #1;
      check("addi_table", got, tbl[i].exp);
      @(negedge clock);
    end

    do_reset();
    push_instr(3'd3, 1'b0, 0, 2);
    push_instr(3'd5, 1'b1, 0, 0);
    push_instr(3'd5, 1'b0, 1, 0);
    push_instr(3'd4, 1'b0, 0, 0);
    push_instr(3'd2, 1'b0, 14, 0);
    push_instr(3'd3, 1'b0, 0, 14);
    run_q("directed");

    for (int i = 0; i < 40; i++)
      push_instr(3'($urandom_range(0, 6)), rnd(), $urandom_range(0, 3), $urandom_range(0, 3));
    run_q("random");

    do_reset();
    for (int i = 0; i < 15; i++)
      push(3'd0, 1'b0, 1'b0, mk(0,0,0,1,0,0,2'b00,0,0,0,0,0,0,3'd0));
    for (int i = 0; i < 5; i++)
      push(3'd0, 1'b0, rnd(), mk(0,0,0,0,0,0,2'b00,0,0,0,0,0,1,3'd6));
    run_q("timeout");

    do_reset();
    push_instr(3'd7, 1'b0, 0, 0);
    run_q("halt");
    do_reset();
    push_instr(3'd1, 1'b0, 0, 0);
    run_q("after_halt");

    push_fetch(3'd4, 0);
    push(3'd4, 1'b0, 1'b0, mk(0,0,0,0,0,0,2'b00,0,0,0,0,0,0,3'd1));
    push_mem(3'd4, 2, 1'b0);
    run_q("sw_wait");
    mem_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("sw_abort", got, 17'd0);
    @(negedge clock);
    reset_n = 1'b1;
    push_instr(3'd6, 1'b0, 0, 0);
    run_q("after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
